// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction cache and its refill controller.
package icache_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } refill_state_e;

    // Default number of words per cache line (power of two, at least 2).
    localparam int DEFAULT_LINE_WORDS = 4;

    // Width of the word offset within a line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Clear the low offset bits of a word address to get the line base.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int ob);
        return (addr >> ob) << ob;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: requests a line, streams beats into the
// data array, commits the tag, and sequences whole-cache invalidation.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  LINE_WORDS = DEFAULT_LINE_WORDS,
    localparam int OFF_BITS   = off_bits(LINE_WORDS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MISS,
    input  logic [WIDTH-1:0]    MISS_ADDR,
    input  logic                FLUSH,
    output logic                STALL,
    output logic                MEM_REQ,
    output logic [WIDTH-1:0]    MEM_ADDR,
    input  logic                MEM_ACK,
    input  logic                MEM_RVALID,
    input  logic [WIDTH-1:0]    MEM_RDATA,
    output logic                FILL_WE,
    output logic [OFF_BITS-1:0] FILL_IDX,
    output logic [WIDTH-1:0]    FILL_DATA,
    output logic                TAG_WE,
    output logic [WIDTH-1:0]    TAG_ADDR,
    output logic                INV_ALL,
    output logic [15:0]         MISS_COUNT
);

    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    refill_state_e       state_q, state_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [OFF_BITS-1:0] cnt_q, cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                count_inc;

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        count_inc    = 1'b0;
        STALL        = 1'b1;
        MEM_REQ      = 1'b0;
        FILL_WE      = 1'b0;
        TAG_WE       = 1'b0;
        INV_ALL      = 1'b0;
        MEM_ADDR     = base_q;
        TAG_ADDR     = base_q;
        FILL_IDX     = cnt_q;
        FILL_DATA    = MEM_RDATA;

        unique case (state_q)
            ST_IDLE: begin
                STALL = MISS | FLUSH | flush_pend_q;
                // A flush (fresh or deferred) wins; the miss is retried next cycle.
                if (FLUSH || flush_pend_q) begin
                    INV_ALL      = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (MISS) begin
                    base_d  = WIDTH'(line_base(64'(MISS_ADDR), OFF_BITS));
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                MEM_REQ = 1'b1;
                if (FLUSH) flush_pend_d = 1'b1;
                if (MEM_ACK) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (FLUSH) flush_pend_d = 1'b1;
                if (MEM_RVALID) begin
                    FILL_WE = 1'b1;
                    cnt_d   = cnt_q + OFF_BITS'(1);
                    if (cnt_q == LAST_BEAT) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                TAG_WE    = 1'b1;
                count_inc = 1'b1;
                if (FLUSH) flush_pend_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, line base, beat counter and deferred-flush registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    sat_counter #(
        .W(16)
    ) u_miss_count (
        .clk   (CLK),
        .rst_n (RST),
        .inc   (count_inc),
        .count (MISS_COUNT)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with a transaction-level reference.
module tb_icache_refill_ctrl;

    localparam int LW = 4;

    logic        CLK;
    logic        RST;
    logic        MISS;
    logic [31:0] MISS_ADDR;
    logic        FLUSH;
    logic        STALL;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic        FILL_WE;
    logic [1:0]  FILL_IDX;
    logic [31:0] FILL_DATA;
    logic        TAG_WE;
    logic [31:0] TAG_ADDR;
    logic        INV_ALL;
    logic [15:0] MISS_COUNT;

    logic        sat_rst_n;
    logic        sat_inc;
    logic [15:0] sat_count;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_count = 0;

    icache_refill_ctrl #(
        .WIDTH      (32),
        .LINE_WORDS (LW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MISS       (MISS),
        .MISS_ADDR  (MISS_ADDR),
        .FLUSH      (FLUSH),
        .STALL      (STALL),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_ACK    (MEM_ACK),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA),
        .FILL_WE    (FILL_WE),
        .FILL_IDX   (FILL_IDX),
        .FILL_DATA  (FILL_DATA),
        .TAG_WE     (TAG_WE),
        .TAG_ADDR   (TAG_ADDR),
        .INV_ALL    (INV_ALL),
        .MISS_COUNT (MISS_COUNT)
    );

    sat_counter #(
        .W(16)
    ) u_sat (
        .clk   (CLK),
        .rst_n (sat_rst_n),
        .inc   (sat_inc),
        .count (sat_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge (input drive point).
    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    // Wait from the drive point to the sampling point mid-cycle.
    task automatic settle();
        #5;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    // One complete refill transaction, checked against expectations derived
    // from the address, handshake delays and beat schedule.
    task automatic do_refill(input logic [31:0] addr, input int ack_dly, input int gap_max,
                             input int flush_beat, input bit stray);
        logic [31:0] base;
        logic [31:0] data;
        int          cyc;
        int          gaps;
        base = addr & ~32'(LW - 1);
        cyc  = 0;

        // Miss cycle: stall raised, no request yet.
        MISS = 1'b1; MISS_ADDR = addr; FLUSH = 1'b0; MEM_ACK = 1'b0;
        MEM_RVALID = stray ? rnd_bit() : 1'b0; MEM_RDATA = $urandom;
        settle();
        check_eq("miss_stall", 64'(STALL), 64'(1));
        check_eq("miss_noreq", 64'(MEM_REQ), 64'(0));
        check_eq("miss_nofill", 64'(FILL_WE), 64'(0));
        advance(); cyc++;
        MISS = 1'b0; MISS_ADDR = $urandom;

        // Request phase: request and address held until the ack cycle.
        for (int d = 0; d <= ack_dly; d++) begin
            MEM_ACK = (d == ack_dly);
            MEM_RVALID = stray ? rnd_bit() : 1'b0; MEM_RDATA = $urandom;
            settle();
            check_eq("req_req", 64'(MEM_REQ), 64'(1));
            check_eq("req_addr", 64'(MEM_ADDR), 64'(base));
            check_eq("req_stall", 64'(STALL), 64'(1));
            check_eq("req_nofill", 64'(FILL_WE), 64'(0));
            advance(); cyc++;
        end
        MEM_ACK = 1'b0;

        // Beats in linear order with optional gaps.
        for (int b = 0; b < LW; b++) begin
            gaps = $urandom_range(gap_max, 0);
            for (int g = 0; g < gaps; g++) begin
                MEM_RVALID = 1'b0;
                settle();
                check_eq("gap_nofill", 64'(FILL_WE), 64'(0));
                check_eq("gap_stall", 64'(STALL), 64'(1));
                check_eq("gap_noreq", 64'(MEM_REQ), 64'(0));
                advance(); cyc++;
            end
            data = $urandom;
            MEM_RVALID = 1'b1; MEM_RDATA = data; FLUSH = (b == flush_beat);
            settle();
            check_eq("beat_we", 64'(FILL_WE), 64'(1));
            check_eq("beat_idx", 64'(FILL_IDX), 64'(b));
            check_eq("beat_data", 64'(FILL_DATA), 64'(data));
            check_eq("beat_stall", 64'(STALL), 64'(1));
            check_eq("beat_inv", 64'(INV_ALL), 64'(0));
            advance(); cyc++;
            FLUSH = 1'b0;
        end

        // Commit cycle: tag write, stray beats ignored.
        MEM_RVALID = stray ? rnd_bit() : 1'b0; MEM_RDATA = $urandom;
        settle();
        check_eq("commit_tag_we", 64'(TAG_WE), 64'(1));
        check_eq("commit_tag_addr", 64'(TAG_ADDR), 64'(base));
        check_eq("commit_inv", 64'(INV_ALL), 64'(0));
        check_eq("commit_nofill", 64'(FILL_WE), 64'(0));
        check_eq("commit_stall", 64'(STALL), 64'(1));
        if (ack_dly == 0 && gap_max == 0)
            check_eq("commit_cycle", 64'(cyc), 64'(LW + 2));
        advance(); cyc++;
        exp_count = (exp_count < 65535) ? exp_count + 1 : 65535;

        // A flush seen during the refill invalidates in the first idle cycle.
        if (flush_beat >= 0) begin
            MEM_RVALID = stray ? rnd_bit() : 1'b0;
            settle();
            check_eq("pend_inv", 64'(INV_ALL), 64'(1));
            check_eq("pend_tag_we", 64'(TAG_WE), 64'(0));
            check_eq("pend_stall", 64'(STALL), 64'(1));
            check_eq("pend_noreq", 64'(MEM_REQ), 64'(0));
            advance(); cyc++;
        end
        MEM_RVALID = stray ? rnd_bit() : 1'b0;
        settle();
        check_eq("idle_stall", 64'(STALL), 64'(0));
        check_eq("idle_inv", 64'(INV_ALL), 64'(0));
        check_eq("idle_nofill", 64'(FILL_WE), 64'(0));
        check_eq("idle_tag_we", 64'(TAG_WE), 64'(0));
        check_eq("miss_count", 64'(MISS_COUNT), 64'(exp_count));
        if (ack_dly == 0 && gap_max == 0 && flush_beat < 0)
            check_eq("idle_cycle", 64'(cyc), 64'(LW + 3));
        $display("refill addr=0x%08h base=0x%08h ack_dly=%0d gap_max=%0d flush_beat=%0d count=%0d",
                 addr, base, ack_dly, gap_max, flush_beat, exp_count);
        advance();
    endtask

    task automatic check_reset_outputs(input string tag);
        settle();
        check_eq({tag, "_stall"}, 64'(STALL), 64'(0));
        check_eq({tag, "_req"}, 64'(MEM_REQ), 64'(0));
        check_eq({tag, "_fill_we"}, 64'(FILL_WE), 64'(0));
        check_eq({tag, "_tag_we"}, 64'(TAG_WE), 64'(0));
        check_eq({tag, "_inv"}, 64'(INV_ALL), 64'(0));
        check_eq({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'(0));
        check_eq({tag, "_tag_addr"}, 64'(TAG_ADDR), 64'(0));
        check_eq({tag, "_fill_idx"}, 64'(FILL_IDX), 64'(0));
        check_eq({tag, "_count"}, 64'(MISS_COUNT), 64'(0));
        advance();
    endtask

    initial begin
        RST = 1'b0; MISS = 1'b0; MISS_ADDR = '0; FLUSH = 1'b0; MEM_ACK = 1'b0;
        MEM_RVALID = 1'b0; MEM_RDATA = '0; sat_rst_n = 1'b0; sat_inc = 1'b0;
        advance(); advance();
        RST = 1'b1;
        exp_count = 0;
        check_reset_outputs("reset");

        // Basic miss at address 5 with fastest handshake.
        do_refill(32'd5, 0, 0, -1, 1'b0);

        // Delayed ack and gapped beats.
        do_refill(32'h0000_1237, 3, 1, -1, 1'b0);

        // FLUSH and MISS together: invalidate first, refill on the next cycle.
        MISS = 1'b1; MISS_ADDR = 32'h0000_0042; FLUSH = 1'b1;
        settle();
        check_eq("coll_inv", 64'(INV_ALL), 64'(1));
        check_eq("coll_noreq", 64'(MEM_REQ), 64'(0));
        check_eq("coll_stall", 64'(STALL), 64'(1));
        $display("flush+miss collision");
        advance();
        do_refill(32'h0000_0042, 0, 0, -1, 1'b0);

        // FLUSH during FILL.
        do_refill(32'h0000_0100, 1, 0, 2, 1'b0);

        // Randomized refills, idle flushes and stray beats.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3, 0) == 0) begin
                MISS = 1'b0; FLUSH = 1'b1; MEM_RVALID = rnd_bit();
                settle();
                check_eq("idle_flush_inv", 64'(INV_ALL), 64'(1));
                check_eq("idle_flush_stall", 64'(STALL), 64'(1));
                check_eq("idle_flush_nofill", 64'(FILL_WE), 64'(0));
                $display("idle flush");
                advance();
                FLUSH = 1'b0;
            end
            do_refill($urandom, $urandom_range(3, 0), $urandom_range(2, 0),
                      ($urandom_range(1, 0) == 1) ? int'($urandom_range(LW - 1, 0)) : -1, 1'b1);
        end

        // Reset during the second beat aborts the refill.
        MISS = 1'b1; MISS_ADDR = 32'h0000_0777; advance(); MISS = 1'b0;
        MEM_ACK = 1'b1; advance(); MEM_ACK = 1'b0;
        MEM_RVALID = 1'b1; MEM_RDATA = 32'h1111; advance();
        MEM_RDATA = 32'h2222; RST = 1'b0; advance();
        RST = 1'b1; exp_count = 0;
        $display("reset during second beat");
        for (int k = 0; k < 4; k++) begin
            MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
            check_reset_outputs("post_rst");
        end
        MEM_RVALID = 1'b0;
        do_refill(32'h0000_0777, 0, 0, -1, 1'b0);

        // Saturation of the 16-bit refill counter.
        sat_rst_n = 1'b0; advance(); sat_rst_n = 1'b1;
        settle();
        check_eq("sat_reset", 64'(sat_count), 64'(0));
        advance();
        sat_inc = 1'b1;
        repeat (65534) advance();
        settle();
        check_eq("sat_fffe", 64'(sat_count), 64'(16'hFFFE));
        advance();
        settle();
        check_eq("sat_ffff", 64'(sat_count), 64'(16'hFFFF));
        repeat (5) advance();
        settle();
        check_eq("sat_hold", 64'(sat_count), 64'(16'hFFFF));
        sat_inc = 1'b0;
        advance();
        settle();
        check_eq("sat_idle_hold", 64'(sat_count), 64'(16'hFFFF));
        $display("saturation count=0x%04h", sat_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
